// File: rtl/zipmem_pkg.sv
// Shared encodings for the pipelined memory unit: op sizes, local-bus
// decode and the outstanding-read bookkeeping record.
package zipmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } op_size_e;

    // Local peripherals live in the first 32 bytes of the 0xc00000xx page
    localparam logic [23:0] LCL_PREFIX = 24'hc00000;

    // One entry per outstanding request, consumed when its ack returns
    typedef struct packed {
        logic [4:0] tag;
        op_size_e   size;
        logic [1:0] off;
    } rd_entry_t;

    function automatic logic is_local(input logic [31:0] addr);
        return (addr[31:8] == LCL_PREFIX) && (addr[7:5] == 3'b000);
    endfunction

    function automatic logic is_misaligned(input op_size_e size, input logic [1:0] off);
        return ((size == SZ_WORD) && (off != 2'b00)) || ((size == SZ_HALF) && off[0]);
    endfunction

endpackage

// File: rtl/pipemem_lanes_if.sv
// Wishbone pipelined bus bundle (global + local CYC/STB) seen by the memory unit.
interface pipemem_lanes_if #(parameter int AW = 30);
    logic          cyc_gbl, cyc_lcl;
    logic          stb_gbl, stb_lcl;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    sel;
    logic          ack, stall, err;
    logic [31:0]   idata;

    modport master (output cyc_gbl, cyc_lcl, stb_gbl, stb_lcl, we, addr, data, sel,
                    input  ack, stall, err, idata);
    modport slave  (input  cyc_gbl, cyc_lcl, stb_gbl, stb_lcl, we, addr, data, sel,
                    output ack, stall, err, idata);
endinterface

// File: rtl/memlane_align.sv
// Big-endian byte-lane steering: write select/replication and read extraction.
module memlane_align
    import zipmem_pkg::*;
(
    input  op_size_e    i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    input  op_size_e    i_rsize,
    input  logic [1:0]  i_roff,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    // Write side: lane select with byte offset 0 on sel[3], data replicated to every lane
    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_WORD: ;
            SZ_HALF: begin
                o_sel   = i_off[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_sel   = 4'b1000 >> i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
        endcase
    end

    // Read side: pick the addressed lane, zero-extend, right-justify
    always_comb begin
        o_rdata = i_rdata;
        case (i_rsize)
            SZ_WORD: ;
            SZ_HALF: o_rdata = {16'h0, (i_roff[1] ? i_rdata[15:0] : i_rdata[31:16])};
            default: begin
                case (i_roff)
                    2'd0:    o_rdata = {24'h0, i_rdata[31:24]};
                    2'd1:    o_rdata = {24'h0, i_rdata[23:16]};
                    2'd2:    o_rdata = {24'h0, i_rdata[15:8]};
                    default: o_rdata = {24'h0, i_rdata[7:0]};
                endcase
            end
        endcase
    end

endmodule

// File: rtl/pipemem_lanes.sv
// Pipelined Wishbone memory unit: issues back-to-back requests on one of two
// buses, tracks outstanding ones in a small FIFO and returns aligned read data.
module pipemem_lanes
    import zipmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 30,
    parameter int LGFIFO         = 4,
    parameter int IMPLEMENT_LOCK = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pipe_stb,
    input  logic                     i_lock,
    input  logic [2:0]               i_op,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_data,
    input  logic [4:0]               i_oreg,
    output logic                     o_busy,
    output logic                     o_pipe_stalled,
    output logic                     o_valid,
    output logic                     o_err,
    output logic [4:0]               o_wreg,
    output logic [31:0]              o_result,
    output logic                     o_wb_cyc_gbl,
    output logic                     o_wb_cyc_lcl,
    output logic                     o_wb_stb_gbl,
    output logic                     o_wb_stb_lcl,
    output logic                     o_wb_we,
    output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
    output logic [31:0]              o_wb_data,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_err,
    input  logic [31:0]              i_wb_data
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int CW    = LGFIFO + 1;

    logic              cyc_gbl_q, cyc_gbl_d, cyc_lcl_q, cyc_lcl_d;
    logic              stb_gbl_q, stb_gbl_d, stb_lcl_q, stb_lcl_d;
    logic              we_q, we_d, valid_q, valid_d, err_q, err_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       data_q, data_d, result_q, result_d;
    logic [3:0]        sel_q, sel_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    rd_entry_t         fifo_q [DEPTH];

    op_size_e    req_size;
    logic [1:0]  req_off;
    rd_entry_t   head;
    logic [3:0]  sel_w;
    logic [31:0] wdata_w, rdata_w;
    logic        busy, stb_any, full, stalled, present, fault, push, pop, use_lcl, cyc_on;

    assign req_size = op_size_e'(i_op[2:1]);
    assign req_off  = i_addr[1:0];
    assign head     = fifo_q[rd_ptr_q];

    assign busy    = cyc_gbl_q | cyc_lcl_q;
    assign stb_any = stb_gbl_q | stb_lcl_q;
    assign full    = (count_q == CW'(DEPTH));
    assign stalled = busy && (i_wb_stall || !stb_any || full);
    // A strobe the unit is ready to take this cycle; misaligned ones fault instead
    assign present = i_pipe_stb && !stalled;
    assign fault   = (present && is_misaligned(req_size, req_off)) || (busy && i_wb_err);
    assign push    = present && !fault;
    assign pop     = busy && i_wb_ack && (count_q != '0) && !fault;
    // The bus is fixed by the first request of a cycle
    assign use_lcl = busy ? cyc_lcl_q : is_local(i_addr);

    memlane_align u_align (
        .i_size  (req_size),
        .i_off   (req_off),
        .i_wdata (i_data),
        .o_sel   (sel_w),
        .o_wdata (wdata_w),
        .i_rsize (head.size),
        .i_roff  (head.off),
        .i_rdata (i_wb_data),
        .o_rdata (rdata_w)
    );

    // Next-state: FIFO bookkeeping, bus cycle/strobe control, result capture
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // CYC stays up while anything is outstanding, or while a locked sequence holds it
        cyc_on   = (count_d != '0) || ((IMPLEMENT_LOCK != 0) && i_lock && busy);
        stb_gbl_d = stb_gbl_q && i_wb_stall;
        stb_lcl_d = stb_lcl_q && i_wb_stall;
        if (push) begin
            stb_gbl_d = !use_lcl;
            stb_lcl_d = use_lcl;
        end
        if (fault) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            cyc_on    = 1'b0;
            stb_gbl_d = 1'b0;
            stb_lcl_d = 1'b0;
        end
        cyc_gbl_d = cyc_on && !use_lcl;
        cyc_lcl_d = cyc_on && use_lcl;
        we_d      = push ? i_op[0] : we_q;
        addr_d    = push ? i_addr[AW+1:2] : addr_q;
        data_d    = push ? wdata_w : data_q;
        sel_d     = push ? sel_w : sel_q;
        valid_d   = pop && !we_q;
        err_d     = fault;
        result_d  = pop ? rdata_w : result_q;
        wreg_d    = pop ? head.tag : wreg_q;
    end

    // Control state, cleared by reset regardless of bus activity
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_gbl_q <= 1'b0;
            cyc_lcl_q <= 1'b0;
            stb_gbl_q <= 1'b0;
            stb_lcl_q <= 1'b0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            cyc_gbl_q <= cyc_gbl_d;
            cyc_lcl_q <= cyc_lcl_d;
            stb_gbl_q <= stb_gbl_d;
            stb_lcl_q <= stb_lcl_d;
            we_q      <= we_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Datapath registers and FIFO storage carry no reset
    always_ff @(posedge i_clk) begin
        addr_q   <= addr_d;
        data_q   <= data_d;
        sel_q    <= sel_d;
        result_q <= result_d;
        wreg_q   <= wreg_d;
        if (push)
            fifo_q[wr_ptr_q] <= '{tag: i_oreg, size: req_size, off: req_off};
    end

    assign o_busy         = busy;
    assign o_pipe_stalled = stalled;
    assign o_valid        = valid_q;
    assign o_err          = err_q;
    assign o_wreg         = wreg_q;
    assign o_result       = result_q;
    assign o_wb_cyc_gbl   = cyc_gbl_q;
    assign o_wb_cyc_lcl   = cyc_lcl_q;
    assign o_wb_stb_gbl   = stb_gbl_q;
    assign o_wb_stb_lcl   = stb_lcl_q;
    assign o_wb_we        = we_q;
    assign o_wb_addr      = addr_q;
    assign o_wb_data      = data_q;
    assign o_wb_sel       = sel_q;

endmodule

// File: doc/pipemem_lanes.md
PIPEMEM_LANES -- requirements
Module: pipemem_lanes
Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 30, width of the word address o_wb_addr (AW).
REQ-002 SHALL have parameter LGFIFO, default 4, log2 of the outstanding-request FIFO depth (legal 1..6).
REQ-003 SHALL have parameter IMPLEMENT_LOCK, default 0, nonzero enables i_lock bus-cycle extension.
REQ-004 SHALL have port i_clk  input  1  the single clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_pipe_stb  input  1  CPU request strobe.
REQ-007 SHALL have port i_lock  input  1  hold CYC across operations (IMPLEMENT_LOCK only).
REQ-008 SHALL have port i_op  input  3  bit0 write; [2:1] size 00 word, 01 halfword, 10 byte.
REQ-009 SHALL have port i_addr  input  32  byte address.
REQ-010 SHALL have port i_data  input  32  write data, right-justified for sub-word ops.
REQ-011 SHALL have port i_oreg  input  5  destination register tag for reads.
REQ-012 SHALL have port o_busy  output  1  bus cycle in progress.
REQ-013 SHALL have port o_pipe_stalled  output  1  CPU must hold its request.
REQ-014 SHALL have port o_valid  output  1  one-cycle read-result strobe.
REQ-015 SHALL have port o_err  output  1  one-cycle bus or alignment error strobe.
REQ-016 SHALL have port o_wreg  output  5  tag accompanying o_valid.
REQ-017 SHALL have port o_result  output  32  read data, zero-extended, right-justified.
REQ-018 SHALL have ports o_wb_cyc_gbl, o_wb_cyc_lcl  output  1 each  per-bus CYC.
REQ-019 SHALL have ports o_wb_stb_gbl, o_wb_stb_lcl  output  1 each  per-bus STB.
REQ-020 SHALL have port o_wb_we  output  1  write enable.
REQ-021 SHALL have port o_wb_addr  output  AW  word address, i_addr[AW+1:2].
REQ-022 SHALL have port o_wb_data  output  32  lane-replicated write data.
REQ-023 SHALL have port o_wb_sel  output  4  byte-lane select, bit3 = byte offset 0 (big-endian).
REQ-024 SHALL have ports i_wb_ack, i_wb_stall, i_wb_err  input  1 each  Wishbone pipelined responses.
REQ-025 SHALL have port i_wb_data  input  32  Wishbone read data.
Function
REQ-026 SHALL select local bus when i_addr[31:8]==24'hc00000 and i_addr[7:5]==0, else global; one bus per cycle, chosen by the first request.
REQ-027 SHALL, idle plus i_pipe_stb with aligned address, assert CYC and STB of the chosen bus next clock and register addr/data/sel/we.
REQ-028 SHALL generate sel: word 1111; halfword 1100 (addr[1]=0) or 0011; byte 4'b1000>>addr[1:0]; data replicated {2{d[15:0]}} / {4{d[7:0]}}.
REQ-029 SHALL, while busy, accept further strobes only when not stalled; caller guarantees same we and bus; STB drops when no strobe and not i_wb_stall.
REQ-030 SHALL push {oreg, size, addr[1:0]} into a 2^LGFIFO FIFO per accepted request and pop per ack; simultaneous push/pop leaves count unchanged; pointers wrap modulo depth.
REQ-031 SHALL drive o_pipe_stalled = busy and (i_wb_stall, or both STBs low, or FIFO count == 2^LGFIFO).
REQ-032 SHALL drop CYC on the clock after the ack that empties the FIFO with no concurrent push.
REQ-033 SHALL assert o_valid one clock after each read ack, o_result = lane extracted by popped size/offset, o_wreg = popped tag; writes produce no o_valid.
REQ-034 SHALL treat i_wb_err or a misaligned strobe (halfword addr[0]=1, word addr[1:0]!=0) as fatal: o_err next clock, CYC/STB low, FIFO flushed, no bus transfer for that strobe.
REQ-035 SHALL, IMPLEMENT_LOCK nonzero, keep the owning CYC high while i_lock remains high after the cycle ends.
Reset
REQ-036 SHALL on i_rst (overriding mid-cycle activity) clear CYCs, STBs, o_valid, o_err, o_busy and FIFO pointers/count; data/addr/sel/o_result/o_wreg unreset.
Structure
REQ-037 SHALL place op-size encodings and local-decode constants in shared package zipmem_pkg; lane steering in sub-module memlane_align.
Verification
REQ-038 SHALL test byte read addr 0x00001003, ack data 0x11223344 -> sel 0001, o_result 0x00000044, o_valid one clock after ack.
REQ-039 SHALL test halfword write addr 0x00001002 data 0x0000ABCD -> sel 0011, o_wb_data 0xABCDABCD, no o_valid.
REQ-040 SHALL test 16 back-to-back reads, acks withheld, LGFIFO=4 -> 16 accepted, stall asserted, then 16 o_valid with tags in order.
REQ-041 SHALL test i_wb_err on 3rd of 5 outstanding reads -> o_err next clock, CYC low, following request starts with empty FIFO.
REQ-042 SHALL test word read at 0x00000006 -> o_err next clock, CYC never asserted; also reset mid-cycle -> all strobes low next clock.
